mult16_sched: RTL and testbench



---
 rtl/mult16_pkg.sv | 20 ++
 rtl/mult16_rsp_fifo.sv | 57 +++++
 rtl/mult16_sched.sv | 132 +++++++++++++
 tb/tb_mult16_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult16_pkg.sv
// Shared widths and record types for the shared-multiplier scheduler.
package mult16_pkg;

  localparam int OPW = 16;
  localparam int PW  = 32;

  // One entry of the tag pipe: whether a product is due and who owns it.
  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } tag_t;

  // Operands of one multiply request.
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           sgn;
  } op_t;

endpackage

// File: rtl/mult16_rsp_fifo.sv
// Per-requester response FIFO; the count output feeds the scheduler's credits.
module mult16_rsp_fifo
  import mult16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [PW-1:0] head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;

  assign valid  = (count != '0);
  assign head   = mem[rptr];
  assign do_pop = pop && valid;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= (wptr == LAST) ? '0 : wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The scheduler's credits must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL));

endmodule

// File: rtl/mult16_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier between
// NREQ requesters, with credit-based flow control into per-requester FIFOs.
module mult16_sched
  import mult16_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LAT       = 3,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ-1:0]     req_signed,
  output logic                mul_valid,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  output logic                mul_signed,
  input  logic [PW-1:0]       mul_p,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [NREQ*PW-1:0]  rsp_p
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(RSP_DEPTH);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] push;
  logic            grant_any;
  logic [1:0]      gid;
  logic [1:0]      rr;
  logic [1:0]      issue_id;
  op_t             sel_op;
  op_t             issue_op;
  op_t             req_op [NREQ];
  tag_t            tag_pipe [LAT];
  tag_t            ret_tag;

  assign req_ready  = grant;
  assign mul_a      = issue_op.a;
  assign mul_b      = issue_op.b;
  assign mul_signed = issue_op.sgn;
  assign ret_tag    = tag_pipe[LAT-1];

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;

    assign req_op[i] = '{a: req_a[i*OPW +: OPW], b: req_b[i*OPW +: OPW], sgn: req_signed[i]};
    // A requester may only issue while a FIFO slot is still unclaimed.
    assign eligible[i] = rst_n && req_valid[i] &&
                         (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_W);
    assign push[i] = ret_tag.vld && (ret_tag.id == 2'(i));

    // Operations issued for this requester whose product has not landed yet.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inflight <= '0;
      end else begin
        case ({grant[i], push[i]})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: inflight <= inflight;
        endcase
      end
    end

    mult16_rsp_fifo #(
      .DEPTH(RSP_DEPTH),
      .CW   (CW)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[i]),
      .push_data(mul_p),
      .pop      (rsp_valid[i] && rsp_ready[i]),
      .valid    (rsp_valid[i]),
      .head     (rsp_p[i*PW +: PW]),
      .count    (fifo_count)
    );
  end

  // Round-robin pick: first eligible requester scanning upward from rr.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    gid       = '0;
    sel_op    = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && eligible[j] && (j == (int'(rr) + k) % NREQ)) begin
          grant_any = 1'b1;
          grant[j]  = 1'b1;
          gid       = 2'(j);
          sel_op    = req_op[j];
        end
      end
    end
  end

  // Pointer advance past the winner and the issue register toward the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      mul_valid <= 1'b0;
      issue_id  <= '0;
      issue_op  <= '0;
    end else begin
      mul_valid <= grant_any;
      if (grant_any) begin
        rr       <= 2'((int'(gid) + 1) % NREQ);
        issue_id <= gid;
        issue_op <= sel_op;
      end
    end
  end

  // Owner tags ride alongside the multiplier so the last stage lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: mul_valid, id: issue_id};
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_mult16_sched.sv
// Self-checking bench for mult16_sched with a behavioural LAT-cycle multiplier
// and a per-requester scoreboard of expected products.
module tb_mult16_sched;

  localparam int NREQ      = 2;
  localparam int LAT       = 3;
  localparam int RSP_DEPTH = 5;
  localparam int TMO       = 100;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_signed;
  logic        mul_valid;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_signed;
  logic [31:0] mul_p;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_p;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] mp [LAT];

  mult16_sched #(
    .NREQ     (NREQ),
    .LAT      (LAT),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_signed(req_signed),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_signed(mul_signed),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: operands extended per signedness, low 32 bits kept.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic [31:0] xa;
    logic [31:0] xb;
    xa = s ? {{16{a[15]}}, a} : {16'h0, a};
    xb = s ? {{16{b[15]}}, b} : {16'h0, b};
    return xa * xb;
  endfunction

  // Behavioural multiplier: product of the issued operands appears LAT cycles later.
  always @(posedge clk) begin
    mp[0] <= ref_mul(mul_a, mul_b, mul_signed);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[LAT-1];

  // One clock: sample handshakes mid-cycle, score responses, then step past the edge.
  task automatic tick();
    logic [31:0] exp_v;
    logic [31:0] got;
    int          qsize;
    @(negedge clk);
    n_cmp++;
    if ((req_ready & (req_ready - 2'd1)) !== 2'd0) begin
      n_bad++;
      $display("[TB] FAIL grant_onehot: req_ready=%b required one-hot or zero", req_ready);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        exp_v = ref_mul(req_a[i*16 +: 16], req_b[i*16 +: 16], req_signed[i]);
        if (i == 0) exp_q0.push_back(exp_v);
        else exp_q1.push_back(exp_v);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        got   = rsp_p[i*32 +: 32];
        qsize = (i == 0) ? exp_q0.size() : exp_q1.size();
        n_cmp++;
        if (qsize == 0) begin
          n_bad++;
          $display("[TB] FAIL rsp_unexpected: req %0d got %h, required no response", i, got);
        end else begin
          if (i == 0) exp_v = exp_q0.pop_front();
          else exp_v = exp_q1.pop_front();
          if (got !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL rsp_product: req %0d got %h, required %h", i, got, exp_v);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_random_ops();
    req_a      = $urandom;
    req_b      = $urandom;
    req_signed = 2'($urandom);
  endtask

  // Stop requesting, accept everything, and require the scoreboard to empty.
  task automatic drain();
    int n;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp_valid != 2'b00) && n < TMO) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= TMO) begin
      n_bad++;
      $display("[TB] FAIL drain: %0d/%0d results still outstanding, required 0",
               exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_req_ready: got %b, required 00", req_ready);
    end
    n_cmp++;
    if ({mul_valid, mul_signed, mul_a, mul_b} !== 34'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_mul: got v=%b s=%b a=%h b=%h, required all 0",
               mul_valid, mul_signed, mul_a, mul_b);
    end
    n_cmp++;
    if ({rsp_valid, rsp_p} !== 66'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_rsp: got v=%b p=%h, required all 0", rsp_valid, rsp_p);
    end
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // 3 x 5 unsigned on requester 0; response visible LAT+2 cycles after the request cycle.
  task automatic test_single();
    int n;
    rsp_ready  = 2'b00;
    req_a      = {16'h0, 16'd3};
    req_b      = {16'h0, 16'd5};
    req_signed = 2'b00;
    req_valid  = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_grant: got %b, required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != LAT + 1) begin
      n_bad++;
      $display("[TB] FAIL single_latency: %0d edges after handshake, required %0d", n, LAT + 1);
    end
    n_cmp++;
    if (rsp_p[31:0] !== 32'h0000000F) begin
      n_bad++;
      $display("[TB] FAIL single_product: got %h, required 0000000f", rsp_p[31:0]);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    n_cmp++;
    if (rsp_valid !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL single_pop: rsp_valid=%b, required 00", rsp_valid);
    end
  endtask

  // Signedness corner cases on requester 1, checked against fixed products.
  task automatic test_signed();
    logic [15:0] opa [3]   = '{16'hFFFE, 16'hFFFE, 16'hFFFF};
    logic [15:0] opb [3]   = '{16'h0003, 16'h0003, 16'hFFFF};
    logic        sgn [3]   = '{1'b1, 1'b0, 1'b0};
    logic [31:0] exp_c [3] = '{32'hFFFFFFFA, 32'h0002FFFA, 32'hFFFE0001};
    int n;
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      req_a      = {opa[k], 16'h0};
      req_b      = {opb[k], 16'h0};
      req_signed = {sgn[k], 1'b0};
      req_valid  = 2'b10;
      #1;
      n_cmp++;
      if (req_ready !== 2'b10) begin
        n_bad++;
        $display("[TB] FAIL signed_grant%0d: got %b, required 10", k, req_ready);
      end
      tick();
    end
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (rsp_valid[1] !== 1'b1 && n < TMO) begin
        tick();
        n++;
      end
      n_cmp++;
      if (n >= TMO || rsp_p[63:32] !== exp_c[k]) begin
        n_bad++;
        $display("[TB] FAIL signed_product%0d: got %h (valid=%b), required %h",
                 k, rsp_p[63:32], rsp_valid[1], exp_c[k]);
      end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
    end
  endtask

  // Both requesting every cycle from reset: grants alternate starting with 0.
  task automatic test_back_to_back();
    logic [1:0] exp_g;
    do_reset();
    rsp_ready = 2'b11;
    for (int c = 0; c < 20; c++) begin
      drive_random_ops();
      req_valid = 2'b11;
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++;
        $display("[TB] FAIL alternate_c%0d: got %b, required %b", c, req_ready, exp_g);
      end
      tick();
    end
    drain();
  endtask

  // Requester 1 stops consuming: it runs out of credit after RSP_DEPTH grants.
  task automatic test_credit_stall();
    int         g1;
    logic [1:0] prev;
    do_reset();
    rsp_ready = 2'b01;
    g1 = 0;
    for (int c = 0; c < 40; c++) begin
      drive_random_ops();
      req_valid = 2'b11;
      #1;
      if (req_ready[1]) g1++;
      if (c >= 30) begin
        n_cmp++;
        if (req_ready[1] !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL stall_blocked_c%0d: req_ready[1]=%b, required 0", c, req_ready[1]);
        end
      end
      tick();
    end
    n_cmp++;
    if (g1 != RSP_DEPTH) begin
      n_bad++;
      $display("[TB] FAIL stall_grants: requester 1 got %0d grants, required %0d", g1, RSP_DEPTH);
    end
    rsp_ready = 2'b11;
    prev = 2'b00;
    for (int c = 0; c < 30; c++) begin
      drive_random_ops();
      req_valid = 2'b11;
      #1;
      if (c >= 12) begin
        n_cmp++;
        if (req_ready === 2'b00 || req_ready === prev) begin
          n_bad++;
          $display("[TB] FAIL restore_alternate_c%0d: got %b after %b, required the other one",
                   c, req_ready, prev);
        end
      end
      prev = req_ready;
      tick();
    end
    drain();
  endtask

  // Reset with operations in flight: outputs clear at once, stale products are ignored.
  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      drive_random_ops();
      req_valid = 2'b11;
      tick();
    end
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mul_valid, mul_signed, mul_a, mul_b} !== 34'h0) begin
      n_bad++;
      $display("[TB] FAIL midreset_mul: got v=%b s=%b a=%h b=%h, required all 0",
               mul_valid, mul_signed, mul_a, mul_b);
    end
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_p} !== 68'h0) begin
      n_bad++;
      $display("[TB] FAIL midreset_rsp: got ready=%b v=%b p=%h, required all 0",
               req_ready, rsp_valid, rsp_p);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 4; c++) begin
      n_cmp++;
      if (rsp_valid !== 2'b00) begin
        n_bad++;
        $display("[TB] FAIL midreset_stale_c%0d: rsp_valid=%b, required 00", c, rsp_valid);
      end
      tick();
    end
  endtask

  // Random valid/ready traffic; every product is scored in order per requester.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive_random_ops();
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_credit_stall();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
